// File: rtl/rocketcpu_debug_bridge_pkg.sv
// Shared constants and state encodings for the UART-to-Wishbone debug bridge.
package rocketcpu_debug_bridge_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        PHY_IDLE,
        PHY_START,
        PHY_DATA,
        PHY_STOP
    } phy_state_e;

    // Byte idx of a 32-bit word, idx 0 being the most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/rocketcpu_debug_bridge_if.sv
// Wishbone initiator bundle driven by the debug bridge.
interface rocketcpu_debug_bridge_if;

    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack;

    modport master (
        output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
        input  i_wb_rdt, i_wb_ack
    );

    modport slave (
        input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
        output i_wb_rdt, i_wb_ack
    );

endinterface

// File: rtl/rocketcpu_debug_uart_phy.sv
// 8N1 UART byte transceiver: synchronized RX deserializer and back-to-back capable TX serializer.
module rocketcpu_debug_uart_phy
    import rocketcpu_debug_bridge_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       tx_o,
    output logic       rx_vld_o,
    output logic [7:0] rx_data_o,
    output logic       rx_ferr_o,
    input  logic       tx_vld_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_rdy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    phy_state_e    rx_st_q, rx_st_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          rx_vld_q, rx_vld_d;
    logic          rx_ferr_q, rx_ferr_d;

    phy_state_e    tx_st_q, tx_st_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic          tx_q, tx_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_st_q   <= PHY_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_vld_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
            tx_st_q   <= PHY_IDLE;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            rx_vld_q  <= rx_vld_d;
            rx_ferr_q <= rx_ferr_d;
            tx_st_q   <= tx_st_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            tx_sh_q   <= tx_sh_d;
            tx_q      <= tx_d;
        end
    end

    // RX: start bit confirmed at mid-bit, then every bit sampled one bit time later.
    always_comb begin
        rx_st_d   = rx_st_q;
        rx_cnt_d  = rx_cnt_q + CW'(1);
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        rx_vld_d  = 1'b0;
        rx_ferr_d = rx_ferr_q;
        case (rx_st_q)
            PHY_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_st_d = PHY_START;
            end
            PHY_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_st_d  = rx_s2_q ? PHY_IDLE : PHY_DATA;
                end
            end
            PHY_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_st_d = PHY_STOP;
                end
            end
            default: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d  = '0;
                    rx_vld_d  = 1'b1;
                    rx_ferr_d = !rx_s2_q;
                    rx_st_d   = PHY_IDLE;
                end
            end
        endcase
    end

    // TX: ready on the final stop-bit cycle so a queued byte follows with no idle gap.
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q + CW'(1);
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        tx_d     = tx_q;
        tx_rdy_o = 1'b0;
        case (tx_st_q)
            PHY_IDLE: begin
                tx_cnt_d = '0;
                tx_d     = 1'b1;
                tx_rdy_o = 1'b1;
                if (tx_vld_i) begin
                    tx_sh_d = tx_data_i;
                    tx_st_d = PHY_START;
                    tx_d    = 1'b0;
                end
            end
            PHY_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    tx_bit_d = '0;
                    tx_st_d  = PHY_DATA;
                    tx_d     = tx_sh_q[0];
                end
            end
            PHY_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_st_d = PHY_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_sh_d  = {1'b1, tx_sh_q[7:1]};
                        tx_d     = tx_sh_q[1];
                    end
                end
            end
            default: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    tx_rdy_o = 1'b1;
                    if (tx_vld_i) begin
                        tx_sh_d = tx_data_i;
                        tx_st_d = PHY_START;
                        tx_d    = 1'b0;
                    end else begin
                        tx_st_d = PHY_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
        endcase
    end

    assign tx_o      = tx_q;
    assign rx_vld_o  = rx_vld_q;
    assign rx_data_o = rx_sh_q;
    assign rx_ferr_o = rx_ferr_q;

endmodule

// File: rtl/rocketcpu_debug_bridge.sv
// UART-driven Wishbone initiator: parses W/R commands, runs one bus cycle, replies K/E (+ read data).
module rocketcpu_debug_bridge
    import rocketcpu_debug_bridge_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT      = 1023
) (
    input  logic i_wb_clk,
    input  logic reset,
    input  logic ser_rx,
    output logic ser_tx,
    output logic o_busy,
    rocketcpu_debug_bridge_if.master wb
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT);

    logic       rx_vld, rx_ferr, tx_vld, tx_rdy;
    logic [7:0] rx_data, tx_data;

    rocketcpu_debug_uart_phy #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_phy (
        .clk_i    (i_wb_clk),
        .rst_i    (reset),
        .rx_i     (ser_rx),
        .tx_o     (ser_tx),
        .rx_vld_o (rx_vld),
        .rx_data_o(rx_data),
        .rx_ferr_o(rx_ferr),
        .tx_vld_i (tx_vld),
        .tx_data_i(tx_data),
        .tx_rdy_o (tx_rdy)
    );

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          cmd_wr_q, cmd_wr_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [31:0]   rdt_q, rdt_d;
    logic          we_q, we_d;
    logic          cyc_q, cyc_d;
    logic [3:0]    sel_q, sel_d;
    logic          err_q, err_d;
    logic          hdr_q, hdr_d;
    logic          done_q, done_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          busy_q;
    logic          last_byte;

    always_ff @(posedge i_wb_clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cmd_wr_q <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            rdt_q    <= '0;
            we_q     <= 1'b0;
            cyc_q    <= 1'b0;
            sel_q    <= '0;
            err_q    <= 1'b0;
            hdr_q    <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_wr_q <= cmd_wr_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            rdt_q    <= rdt_d;
            we_q     <= we_d;
            cyc_q    <= cyc_d;
            sel_q    <= sel_d;
            err_q    <= err_d;
            hdr_q    <= hdr_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    // Write replies stop after the status byte; an error reply never carries data.
    assign last_byte = hdr_q ? (err_q || cmd_wr_q) : (cnt_q == 2'd3);
    assign tx_data   = hdr_q ? (err_q ? RSP_ERR : RSP_OK) : word_byte(rdt_q, cnt_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_wr_d = cmd_wr_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        rdt_d    = rdt_q;
        we_d     = we_q;
        cyc_d    = cyc_q;
        sel_d    = sel_q;
        err_d    = err_q;
        hdr_d    = hdr_q;
        done_d   = done_q;
        tmo_d    = tmo_q;
        tx_vld   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_vld && !rx_ferr && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
                    state_d  = ST_ADDR;
                    cnt_d    = '0;
                    cmd_wr_d = (rx_data == CMD_WR);
                end
            end
            ST_ADDR: begin
                if (rx_vld) begin
                    if (rx_ferr) begin
                        state_d = ST_IDLE;
                    end else begin
                        adr_d = {adr_q[23:0], rx_data};
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d = cmd_wr_q ? ST_DATA : ST_BUS;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (rx_vld) begin
                    if (rx_ferr) begin
                        state_d = ST_IDLE;
                    end else begin
                        dat_d = {dat_q[23:0], rx_data};
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d = ST_BUS;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            ST_BUS: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    we_d  = cmd_wr_q;
                    sel_d = 4'hF;
                    tmo_d = '0;
                end else if (wb.i_wb_ack || tmo_q == TMO_LAST) begin
                    // An ack on the timeout cycle still wins over the abort.
                    if (wb.i_wb_ack && !cmd_wr_q) rdt_d = wb.i_wb_rdt;
                    err_d   = !wb.i_wb_ack;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    hdr_d   = 1'b1;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_RESP: begin
                tx_vld = !done_q;
                if (tx_vld && tx_rdy) begin
                    hdr_d = 1'b0;
                    if (last_byte)   done_d = 1'b1;
                    else if (!hdr_q) cnt_d  = cnt_q + 2'd1;
                end
                // tx_rdy after the last hand-off marks the final stop-bit cycle.
                if (done_q && tx_rdy) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wb.o_wb_adr = adr_q;
    assign wb.o_wb_dat = dat_q;
    assign wb.o_wb_sel = sel_q;
    assign wb.o_wb_we  = we_q;
    assign wb.o_wb_cyc = cyc_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_rocketcpu_debug_bridge.sv
// Directed bench: host UART model, configurable Wishbone responder and reply decoder.
module tb_rocketcpu_debug_bridge;

    localparam int CPB = 8;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ser_rx = 1'b1;
    logic ser_tx;
    logic o_busy;

    rocketcpu_debug_bridge_if wb();

    rocketcpu_debug_bridge #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT     (TMO)
    ) dut (
        .i_wb_clk(clk),
        .reset   (reset),
        .ser_rx  (ser_rx),
        .ser_tx  (ser_tx),
        .o_busy  (o_busy),
        .wb      (wb)
    );

    always #5 clk = ~clk;

    // Responder: acks ack_dly cycles after cyc rises (0 = same cycle), never when ack_en is low.
    logic        ack_en  = 1'b1;
    int          ack_dly = 0;
    logic [31:0] rdt_val = '0;
    int          age = 0;

    always @(posedge clk) age <= wb.o_wb_cyc ? age + 1 : 0;
    assign wb.i_wb_ack = wb.o_wb_cyc && ack_en && (age == ack_dly);
    assign wb.i_wb_rdt = rdt_val;

    // Bus monitor, sampled on the falling edge.
    int          txn_count = 0, cur_len = 0, last_len = 0, stable_err = 0;
    logic [31:0] adr0, dat0, cap_adr, cap_dat;
    logic        we0, cap_we;
    logic [3:0]  cap_sel;

    always @(negedge clk) begin
        if (wb.o_wb_cyc) begin
            cur_len <= cur_len + 1;
            if (cur_len == 0) begin
                adr0 <= wb.o_wb_adr;
                dat0 <= wb.o_wb_dat;
                we0  <= wb.o_wb_we;
            end
            if (wb.o_wb_sel != 4'hF || (cur_len != 0 &&
                (wb.o_wb_adr != adr0 || wb.o_wb_dat != dat0 || wb.o_wb_we != we0)))
                stable_err <= stable_err + 1;
            if (wb.i_wb_ack) begin
                txn_count <= txn_count + 1;
                cap_adr   <= wb.o_wb_adr;
                cap_dat   <= wb.o_wb_dat;
                cap_we    <= wb.o_wb_we;
                cap_sel   <= wb.o_wb_sel;
            end
        end else if (cur_len != 0) begin
            last_len <= cur_len;
            cur_len  <= 0;
        end
    end

    // Reply decoder: every received byte is appended; bad stop bits are counted.
    logic [7:0] rep[$];
    int         tx_ferr = 0;

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge ser_tx);
            repeat (CPB / 2) @(posedge clk);
            #1;
            if (ser_tx == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    #1;
                    b[i] = ser_tx;
                end
                repeat (CPB) @(posedge clk);
                #1;
                if (ser_tx != 1'b1) tx_ferr++;
                rep.push_back(b);
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int rd_idx  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        ser_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        ser_rx = stop;
        repeat (CPB) @(negedge clk);
        ser_rx = 1'b1;
        if (!stop) repeat (CPB) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] a, d;
        a = adr;
        d = dat;
        send_byte(cmd, 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], 1'b1);
        if (cmd == 8'h57)
            for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        repeat (2) @(posedge clk);
        while (o_busy && n < 4000) begin
            @(posedge clk);
            n++;
        end
        check_eq({tag, "_finished"}, 32'(n < 4000), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    // Checks that exactly n new reply bytes arrived, matching exp (first byte in exp[39:32]).
    task automatic expect_replies(input string tag, input int n, input logic [39:0] exp);
        logic [39:0] e;
        logic [31:0] got;
        e = exp;
        check_eq({tag, "_nbytes"}, 32'(rep.size() - rd_idx), 32'(n));
        for (int i = 0; i < n; i++) begin
            got = (rd_idx + i < rep.size()) ? {24'd0, rep[rd_idx + i]} : 32'h100;
            check_eq($sformatf("%s_byte%0d", tag, i), got, {24'd0, e[8*(4-i) +: 8]});
        end
        rd_idx = rep.size();
    endtask

    initial begin
        int base;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ser_tx", {31'd0, ser_tx}, 32'd1);
        check_eq("rst_cyc", {31'd0, wb.o_wb_cyc}, 32'd0);
        check_eq("rst_we", {31'd0, wb.o_wb_we}, 32'd0);
        check_eq("rst_sel", {28'd0, wb.o_wb_sel}, 32'd0);
        check_eq("rst_adr", wb.o_wb_adr, 32'd0);
        check_eq("rst_dat", wb.o_wb_dat, 32'd0);
        check_eq("rst_busy", {31'd0, o_busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Write, acked one cycle after cyc rises.
        ack_en = 1'b1; ack_dly = 1;
        base = txn_count;
        send_byte(8'h57, 1'b1);
        check_eq("wr_busy_after_cmd", {31'd0, o_busy}, 32'd1);
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
        send_byte(8'hDE, 1'b1); send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1);
        wait_idle("wr");
        check_eq("wr_txn", 32'(txn_count - base), 32'd1);
        check_eq("wr_adr", cap_adr, 32'h0000_0010);
        check_eq("wr_dat", cap_dat, 32'hDEAD_BEEF);
        check_eq("wr_we", {31'd0, cap_we}, 32'd1);
        check_eq("wr_sel", {28'd0, cap_sel}, 32'hF);
        check_eq("wr_cyc_len", 32'(last_len), 32'd2);
        expect_replies("wr_rep", 1, 40'h4B_0000_0000);

        // Read, acked three cycles after cyc rises.
        ack_dly = 3; rdt_val = 32'hDEAD_BEEF;
        base = txn_count;
        send_cmd(8'h52, 32'h0000_0010, 32'd0);
        wait_idle("rd");
        check_eq("rd_txn", 32'(txn_count - base), 32'd1);
        check_eq("rd_adr", cap_adr, 32'h0000_0010);
        check_eq("rd_we", {31'd0, cap_we}, 32'd0);
        check_eq("rd_cyc_len", 32'(last_len), 32'd4);
        expect_replies("rd_rep", 5, 40'h4B_DEAD_BEEF);

        // Read with combinational ack: a one-cycle transaction.
        ack_dly = 0; rdt_val = 32'h1234_5678;
        base = txn_count;
        send_cmd(8'h52, 32'h0200_0000, 32'd0);
        wait_idle("comb");
        check_eq("comb_txn", 32'(txn_count - base), 32'd1);
        check_eq("comb_adr", cap_adr, 32'h0200_0000);
        check_eq("comb_cyc_len", 32'(last_len), 32'd1);
        expect_replies("comb_rep", 5, 40'h4B_1234_5678);

        // Read that is never acked: abort after TIMEOUT+1 cycles with 'E'.
        ack_en = 1'b0;
        base = txn_count;
        send_cmd(8'h52, 32'h0300_0004, 32'd0);
        wait_idle("tmo");
        check_eq("tmo_txn", 32'(txn_count - base), 32'd0);
        check_eq("tmo_cyc_len", 32'(last_len), 32'(TMO + 1));
        check_eq("tmo_cyc_low", {31'd0, wb.o_wb_cyc}, 32'd0);
        check_eq("tmo_busy", {31'd0, o_busy}, 32'd0);
        expect_replies("tmo_rep", 1, 40'h45_0000_0000);

        // Junk bytes and an 'R' whose address byte has a bad stop bit are dropped.
        ack_en = 1'b1; ack_dly = 0; rdt_val = 32'hA5A5_5A5A;
        base = txn_count;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (8 * CPB) @(negedge clk);
        check_eq("ferr_busy", {31'd0, o_busy}, 32'd0);
        check_eq("ferr_txn", 32'(txn_count - base), 32'd0);
        expect_replies("ferr_rep", 0, 40'd0);
        send_cmd(8'h52, 32'h0000_0004, 32'd0);
        wait_idle("ferr_next");
        check_eq("ferr_next_txn", 32'(txn_count - base), 32'd1);
        check_eq("ferr_next_adr", cap_adr, 32'h0000_0004);
        expect_replies("ferr_next_rep", 5, 40'h4B_A5A5_5A5A);

        // Reset while the bus cycle is pending.
        ack_en = 1'b0;
        send_cmd(8'h52, 32'h0000_0008, 32'd0);
        n = 0;
        while (!wb.o_wb_cyc && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check_eq("rst_mid_cyc_seen", 32'(n < 2000), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_cyc", {31'd0, wb.o_wb_cyc}, 32'd0);
        check_eq("rst_mid_ser_tx", {31'd0, ser_tx}, 32'd1);
        check_eq("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ack_en = 1'b1; ack_dly = 0;
        repeat (4) @(negedge clk);
        base = txn_count;
        send_cmd(8'h57, 32'h0000_0020, 32'h0102_0304);
        wait_idle("post_rst");
        check_eq("post_rst_txn", 32'(txn_count - base), 32'd1);
        check_eq("post_rst_adr", cap_adr, 32'h0000_0020);
        check_eq("post_rst_dat", cap_dat, 32'h0102_0304);
        check_eq("post_rst_we", {31'd0, cap_we}, 32'd1);
        expect_replies("post_rst_rep", 1, 40'h4B_0000_0000);

        check_eq("bus_stable", 32'(stable_err), 32'd0);
        check_eq("tx_stop_bits", 32'(tx_ferr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
